// File: rtl/ts_pkg.sv
// Shared constants, FSM state type and sizing helper for the TS packet arbiter.
package ts_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'h47;
   localparam int         PKT_LEN   = 188;

   typedef enum logic {
      IDLE,
      XFER
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible channel after last_gnt, wrapping.
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int IW   = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] eligible,
   input  logic [IW-1:0]   last_gnt,
   output logic [N_CH-1:0] next_gnt
);

   logic found;

   // Offsets are scanned nearest-first; constant indices keep the search shallow.
   always_comb begin
      next_gnt = '0;
      found    = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         for (int i = 0; i < N_CH; i++) begin
            if (!found && eligible[i] &&
                ((int'(last_gnt) + k == i) || (int'(last_gnt) + k == i + N_CH))) begin
               next_gnt[i] = 1'b1;
               found       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ts_packet_arbiter.sv
// Packet-atomic round-robin arbiter: streams whole TS packets from N_CH channels
// onto one registered byte bus with backpressure, sync checking and packet counters.
module ts_packet_arbiter #(
   parameter int         N_CH      = 4,
   parameter int         PKT_LEN   = ts_pkg::PKT_LEN,
   parameter int         CNT_W     = 16,
   parameter logic [7:0] SYNC_BYTE = ts_pkg::SYNC_BYTE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       ch_en,
   input  logic [N_CH-1:0]       req,
   input  logic [8*N_CH-1:0]     in_data,
   output logic [N_CH-1:0]       rd,
   output logic [N_CH-1:0]       gnt,
   output logic                  busy,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   output logic                  out_sop,
   output logic                  out_eop,
   input  logic                  out_ready,
   output logic                  sync_err,
   output logic [CNT_W*N_CH-1:0] pkt_cnt
);

   import ts_pkg::*;

   localparam int            BW        = clog2(PKT_LEN + 1);
   localparam int            IW        = $clog2(N_CH);
   localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_LEN - 1);
   localparam logic [BW-1:0] LEN_C     = BW'(PKT_LEN);
   localparam logic [IW-1:0] LAST_CH   = IW'(N_CH - 1);

   state_t            state, state_nxt;
   logic [BW-1:0]     byte_cnt;
   logic [IW-1:0]     last_gnt, g_idx;
   logic [N_CH-1:0]   eligible, next_gnt;
   logic [7:0]        sel_byte;
   logic              adv, rd_en, last_rd;
   logic [CNT_W-1:0]  cnt_q [N_CH];

   assign eligible = req & ch_en;
   assign adv      = !out_valid || out_ready;
   assign last_rd  = rd_en && (byte_cnt == LAST_BYTE);

   rr_arbiter #(.N_CH(N_CH), .IW(IW)) u_rr (
      .eligible (eligible),
      .last_gnt (last_gnt),
      .next_gnt (next_gnt)
   );

   // Grant is one-hot, so OR-reducing the gated lanes selects the head byte.
   always_comb begin
      g_idx    = '0;
      sel_byte = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt[i]) begin
            g_idx    = IW'(i);
            sel_byte = sel_byte | in_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (|eligible) state_nxt = XFER;
         XFER: if (last_rd)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state == XFER);
      rd_en = busy && adv && (byte_cnt < LEN_C);
      rd    = rd_en ? gnt : '0;
   end

   // The output register only moves when the downstream slot is free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt       <= '0;
         byte_cnt  <= '0;
         last_gnt  <= LAST_CH;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         sync_err  <= 1'b0;
         for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
      end else begin
         sync_err <= rd_en && (byte_cnt == '0) && (sel_byte != SYNC_BYTE);
         if (state == IDLE && |eligible) begin
            gnt      <= next_gnt;
            byte_cnt <= '0;
         end
         if (rd_en) begin
            out_data  <= sel_byte;
            out_valid <= 1'b1;
            out_sop   <= (byte_cnt == '0);
            out_eop   <= (byte_cnt == LAST_BYTE);
            byte_cnt  <= byte_cnt + 1'b1;
         end else if (adv) begin
            out_valid <= 1'b0;
         end
         if (last_rd) begin
            gnt      <= '0;
            last_gnt <= g_idx;
            for (int c = 0; c < N_CH; c++) begin
               if (gnt[c]) cnt_q[c] <= cnt_q[c] + 1'b1;
            end
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_cnt
      assign pkt_cnt[CNT_W*c +: CNT_W] = cnt_q[c];
   end

endmodule
